// File: rtl/abc_handshake_ctrl.sv
// Initiator-side sequencer for the a/b/c handshake: drive request a, wait for
// acknowledge b within a bounded window, then drive data strobe c.
module abc_handshake_ctrl #(
  parameter int MAX_A_LEN = 2,
  parameter int MAX_WAIT  = 3,
  parameter int MAX_C_LEN = 2,
  parameter int CNT_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] a_len,
  input  logic [CNT_W-1:0] c_len,
  input  logic             b,
  output logic             a,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] ack_lat
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DATA} state_t;

  localparam logic [CNT_W-1:0] A_MAX = CNT_W'(MAX_A_LEN);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_C_LEN);
  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] a_len_q, a_len_n;
  logic [CNT_W-1:0] c_len_q, c_len_n;
  logic [CNT_W-1:0] lat_q, lat_n;
  logic             timeout_q, timeout_n;

  // A zero length still produces one cycle; oversized lengths saturate.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len,
                                                 input logic [CNT_W-1:0] max);
    if (len == '0)
      return ONE;
    else if (len > max)
      return max;
    else
      return len;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_len_q   <= '0;
      c_len_q   <= '0;
      lat_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      a_len_q   <= a_len_n;
      c_len_q   <= c_len_n;
      lat_q     <= lat_n;
      timeout_q <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    a_len_n   = a_len_q;
    c_len_n   = c_len_q;
    lat_n     = lat_q;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          a_len_n = clamp_len(a_len, A_MAX);
          c_len_n = clamp_len(c_len, C_MAX);
          cnt_n   = ONE;
          state_n = REQ;
        end
      end
      REQ: begin
        if (cnt == a_len_q) begin
          cnt_n   = ONE;
          state_n = WAIT;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      WAIT: begin
        // cnt holds the index of the current window cycle, recorded as latency.
        if (b) begin
          lat_n   = cnt;
          cnt_n   = ONE;
          state_n = DATA;
        end else if (cnt == W_MAX) begin
          cnt_n     = '0;
          timeout_n = 1'b1;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      DATA: begin
        if (cnt == c_len_q) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign a       = (state == REQ);
  assign c       = (state == DATA);
  assign busy    = (state != IDLE);
  assign done    = (state == DATA) && (cnt == c_len_q);
  assign timeout = timeout_q;
  assign ack_lat = done ? lat_q : '0;

endmodule

// File: tb/tb_abc_handshake_ctrl.sv
// Directed self-checking bench for abc_handshake_ctrl with hand-derived
// cycle-by-cycle expectations and always-on protocol monitors.
module tb_abc_handshake_ctrl;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] a_len;
  logic [CNT_W-1:0] c_len;
  logic             b;
  logic             a;
  logic             c;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] ack_lat;

  int checks   = 0;
  int failures = 0;
  logic mon_en  = 1'b0;
  logic pend_c  = 1'b0;

  abc_handshake_ctrl #(
    .MAX_A_LEN(2),
    .MAX_WAIT (3),
    .MAX_C_LEN(2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_len  (a_len),
    .c_len  (c_len),
    .b      (b),
    .a      (a),
    .c      (c),
    .busy   (busy),
    .done   (done),
    .timeout(timeout),
    .ack_lat(ack_lat)
  );

  always #5 clk = ~clk;

  // After tick, outputs show the current cycle and inputs set now are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [CNT_W-1:0] al,
                               input logic [CNT_W-1:0] cl, input logic bb,
                               input logic rr);
    start = st;
    a_len = al;
    c_len = cl;
    b     = bb;
    rst   = rr;
  endtask

  task automatic checkOutput(input string tag, input logic ea, input logic ec,
                             input logic eb, input logic ed, input logic et,
                             input logic [CNT_W-1:0] el);
    logic [CNT_W+4:0] obs;
    logic [CNT_W+4:0] exp;
    obs = {a, c, busy, done, timeout, ack_lat};
    exp = {ea, ec, eb, ed, et, el};
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed a,c,busy,done,timeout,ack_lat=%b required=%b", tag, obs, exp);
    end
  endtask

  // Protocol monitors: a/c exclusion, done/timeout exclusion, b in window implies c next cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert (!(a && c))
      else begin
        failures++;
        $error("[TB] FAIL a_and_c observed a=%b c=%b required not both", a, c);
      end
      checks++;
      assert (!(done && timeout))
      else begin
        failures++;
        $error("[TB] FAIL done_and_timeout observed done=%b timeout=%b required not both", done, timeout);
      end
      if (pend_c) begin
        checks++;
        assert (c === 1'b1)
        else begin
          failures++;
          $error("[TB] FAIL b_then_c observed c=%b required 1", c);
        end
      end
      pend_c <= busy && !a && !c && b && !rst;
    end
  end

  initial begin
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    tick();
    checkOutput("reset_c1", 0, 0, 0, 0, 0, 2'd0);
    tick();
    checkOutput("reset_c2", 0, 0, 0, 0, 0, 2'd0);
    mon_en = 1'b1;

    // Full-length transaction, ack in window cycle 2.
    applyStimulus(1'b1, 2'd2, 2'd2, 1'b0, 1'b0);
    checkOutput("full_t0_idle", 0, 0, 0, 0, 0, 2'd0);
    tick(); applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("full_t1_a", 1, 0, 1, 0, 0, 2'd0);
    tick(); checkOutput("full_t2_a", 1, 0, 1, 0, 0, 2'd0);
    tick(); checkOutput("full_t3_w1", 0, 0, 1, 0, 0, 2'd0);
    tick(); b = 1'b1;
    checkOutput("full_t4_w2", 0, 0, 1, 0, 0, 2'd0);
    tick(); b = 1'b0;
    checkOutput("full_t5_c", 0, 1, 1, 0, 0, 2'd0);
    tick(); checkOutput("full_t6_done", 0, 1, 1, 1, 0, 2'd2);
    tick(); checkOutput("full_t7_idle", 0, 0, 0, 0, 0, 2'd0);

    // Timeout with b held low.
    applyStimulus(1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
    tick(); start = 1'b0;
    checkOutput("to_t1_a", 1, 0, 1, 0, 0, 2'd0);
    for (int k = 1; k <= 3; k++) begin
      tick(); checkOutput($sformatf("to_w%0d", k), 0, 0, 1, 0, 0, 2'd0);
    end
    tick(); checkOutput("to_pulse", 0, 0, 0, 0, 1, 2'd0);
    tick(); checkOutput("to_after", 0, 0, 0, 0, 0, 2'd0);

    // Clamping (a_len 0 -> 1, c_len 3 -> 2) and b during REQ ignored.
    applyStimulus(1'b1, 2'd0, 2'd3, 1'b1, 1'b0);
    checkOutput("clamp_t0_idle", 0, 0, 0, 0, 0, 2'd0);
    tick(); start = 1'b0;
    checkOutput("clamp_t1_a", 1, 0, 1, 0, 0, 2'd0);
    tick(); checkOutput("clamp_t2_w1", 0, 0, 1, 0, 0, 2'd0);
    tick(); b = 1'b0;
    checkOutput("clamp_t3_c", 0, 1, 1, 0, 0, 2'd0);
    tick(); checkOutput("clamp_t4_done", 0, 1, 1, 1, 0, 2'd1);
    tick(); checkOutput("clamp_t5_idle", 0, 0, 0, 0, 0, 2'd0);

    // Reset in the first c cycle, then a clean transaction.
    applyStimulus(1'b1, 2'd1, 2'd2, 1'b0, 1'b0);
    tick(); start = 1'b0;
    checkOutput("rst_t1_a", 1, 0, 1, 0, 0, 2'd0);
    tick(); b = 1'b1;
    checkOutput("rst_t2_w1", 0, 0, 1, 0, 0, 2'd0);
    tick(); b = 1'b0; rst = 1'b1;
    checkOutput("rst_t3_c", 0, 1, 1, 0, 0, 2'd0);
    tick(); rst = 1'b0;
    checkOutput("rst_t4_dropped", 0, 0, 0, 0, 0, 2'd0);
    tick(); checkOutput("rst_t5_idle", 0, 0, 0, 0, 0, 2'd0);
    applyStimulus(1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
    tick(); start = 1'b0;
    checkOutput("post_t1_a", 1, 0, 1, 0, 0, 2'd0);
    tick(); b = 1'b1;
    checkOutput("post_t2_w1", 0, 0, 1, 0, 0, 2'd0);
    tick(); b = 1'b0;
    checkOutput("post_t3_done", 0, 1, 1, 1, 0, 2'd1);
    tick(); checkOutput("post_t4_idle", 0, 0, 0, 0, 0, 2'd0);

    // Back-to-back with start held high and ack in window cycle 3.
    applyStimulus(1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
    tick(); checkOutput("b2b_t1_a", 1, 0, 1, 0, 0, 2'd0);
    tick(); checkOutput("b2b_t2_w1", 0, 0, 1, 0, 0, 2'd0);
    tick(); checkOutput("b2b_t3_w2", 0, 0, 1, 0, 0, 2'd0);
    tick(); b = 1'b1;
    checkOutput("b2b_t4_w3", 0, 0, 1, 0, 0, 2'd0);
    tick(); b = 1'b0;
    checkOutput("b2b_t5_done", 0, 1, 1, 1, 0, 2'd3);
    tick(); checkOutput("b2b_t6_idle", 0, 0, 0, 0, 0, 2'd0);
    tick(); start = 1'b0;
    checkOutput("b2b_t7_a2", 1, 0, 1, 0, 0, 2'd0);
    for (int k = 1; k <= 3; k++) begin
      tick(); checkOutput($sformatf("b2b_second_w%0d", k), 0, 0, 1, 0, 0, 2'd0);
    end
    tick(); checkOutput("b2b_second_timeout", 0, 0, 0, 0, 1, 2'd0);
    tick(); checkOutput("b2b_final_idle", 0, 0, 0, 0, 0, 2'd0);

    mon_en = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
